// File: rtl/legv8_pkg.sv
// Shared LEGv8 control definitions: sequencer states, PC-select encodings,
// branch opcode/condition constants and small decode helpers.
package legv8_pkg;

  localparam int XLEN = 64;
  localparam int ILEN = 32;

  // Multicycle sequencer states
  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_UPDATE = 3'd3,
    S_HALT   = 3'd4
  } seq_state_t;

  // Program-counter next-value select
  localparam logic [1:0] PS_HOLD   = 2'b00;
  localparam logic [1:0] PS_LOAD   = 2'b01;
  localparam logic [1:0] PS_INC    = 2'b10;
  localparam logic [1:0] PS_BRANCH = 2'b11;

  // Branch opcodes (compared against the leading instruction bits)
  localparam logic [5:0]  OP_B     = 6'b000101;
  localparam logic [5:0]  OP_BL    = 6'b100101;
  localparam logic [7:0]  OP_CBZ   = 8'b10110100;
  localparam logic [7:0]  OP_CBNZ  = 8'b10110101;
  localparam logic [7:0]  OP_BCOND = 8'b01010100;
  localparam logic [10:0] OP_BR    = 11'b11010110000;

  // B.cond condition codes
  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_HS = 4'b0010;
  localparam logic [3:0] COND_LO = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  // Branch class of an instruction word
  typedef enum logic [2:0] {
    BR_NONE  = 3'd0,
    BR_B     = 3'd1,
    BR_BL    = 3'd2,
    BR_CBZ   = 3'd3,
    BR_CBNZ  = 3'd4,
    BR_BCOND = 3'd5,
    BR_REG   = 3'd6
  } br_class_t;

  function automatic br_class_t decode_branch(input logic [ILEN-1:0] ir);
    br_class_t cls;
    cls = BR_NONE;
    if (ir[31:26] == OP_B)            cls = BR_B;
    else if (ir[31:26] == OP_BL)      cls = BR_BL;
    else if (ir[31:24] == OP_CBZ)     cls = BR_CBZ;
    else if (ir[31:24] == OP_CBNZ)    cls = BR_CBNZ;
    else if (ir[31:24] == OP_BCOND)   cls = BR_BCOND;
    else if (ir[31:21] == OP_BR)      cls = BR_REG;
    return cls;
  endfunction

  // Word offset of B/BL, sign-extended
  function automatic logic [XLEN-1:0] sext_imm26(input logic [25:0] imm);
    return {{(XLEN-26){imm[25]}}, imm};
  endfunction

  // Word offset of CBZ/CBNZ/B.cond, sign-extended
  function automatic logic [XLEN-1:0] sext_imm19(input logic [18:0] imm);
    return {{(XLEN-19){imm[18]}}, imm};
  endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Bundle between the PC sequencer and its neighbours: instruction memory,
// ALU flags, register-file target and the program counter controls.
interface pc_sequencer_if
  import legv8_pkg::*;
#(
  parameter int RETIRE_W = 32
);
  logic [ILEN-1:0]     instr;
  logic                imem_ready;
  logic                alu_zero;
  logic [3:0]          flags;
  logic [XLEN-1:0]     reg_target;
  logic [1:0]          PS;
  logic [XLEN-1:0]     PC_in;
  logic [ILEN-1:0]     ir;
  logic                ir_load;
  logic                link_write;
  logic                halted;
  logic [RETIRE_W-1:0] retired;

  // The sequencer side
  modport master (
    input  instr, imem_ready, alu_zero, flags, reg_target,
    output PS, PC_in, ir, ir_load, link_write, halted, retired
  );

  // Memory / datapath side
  modport slave (
    output instr, imem_ready, alu_zero, flags, reg_target,
    input  PS, PC_in, ir, ir_load, link_write, halted, retired
  );
endinterface

// File: rtl/cond_eval.sv
// B.cond evaluator: condition code x {N,Z,C,V} -> take. Purely combinational
// so the pipelined core can reuse it in its own branch stage.
module cond_eval
  import legv8_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       take
);

  logic n_f, z_f, c_f, v_f;
  logic base;

  assign n_f = flags[3];
  assign z_f = flags[2];
  assign c_f = flags[1];
  assign v_f = flags[0];

  // Even codes test a predicate, odd codes its inverse; the 111x pair is always
  always_comb begin
    base = 1'b1;
    case (cond[3:1])
      COND_EQ[3:1]: base = z_f;
      COND_HS[3:1]: base = c_f;
      COND_MI[3:1]: base = n_f;
      COND_VS[3:1]: base = v_f;
      COND_HI[3:1]: base = c_f & ~z_f;
      COND_GE[3:1]: base = (n_f == v_f);
      COND_GT[3:1]: base = ~z_f & (n_f == v_f);
      default:      base = 1'b1;
    endcase
    take = (cond[0] && (cond[3:1] != COND_AL[3:1])) ? ~base : base;
  end

endmodule

// File: rtl/pc_sequencer.sv
// Multicycle PC sequencer: FETCH -> DECODE -> EXEC -> UPDATE, one PC update
// per instruction, HALT on an all-zero instruction word.
module pc_sequencer
  import legv8_pkg::*;
#(
  parameter int RETIRE_W = 32
) (
  input  logic           clock,
  input  logic           reset,
  pc_sequencer_if.master bus
);

  seq_state_t          state_reg;
  logic [ILEN-1:0]     ir_reg;
  logic [1:0]          ps_reg;
  logic [XLEN-1:0]     pc_in_reg;
  logic                link_reg;
  logic                halted_reg;
  logic [RETIRE_W-1:0] retired_reg;

  br_class_t           br_class;
  logic                cond_take;

  assign br_class = decode_branch(ir_reg);

  cond_eval u_cond_eval (
    .cond  (ir_reg[3:0]),
    .flags (bus.flags),
    .take  (cond_take)
  );

  // Strobe coincides with the capturing edge; suppressed while in reset
  assign bus.ir_load    = (state_reg == S_FETCH) && bus.imem_ready && !reset;
  assign bus.PS         = ps_reg;
  assign bus.PC_in      = pc_in_reg;
  assign bus.ir         = ir_reg;
  assign bus.link_write = link_reg;
  assign bus.halted     = halted_reg;
  assign bus.retired    = retired_reg;

  // Sequencer FSM; PC controls are registered so they are valid for exactly the UPDATE cycle
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg   <= S_FETCH;
      ir_reg      <= '0;
      ps_reg      <= PS_HOLD;
      pc_in_reg   <= '0;
      link_reg    <= 1'b0;
      halted_reg  <= 1'b0;
      retired_reg <= '0;
    end else begin
      case (state_reg)
        S_FETCH: begin
          if (bus.imem_ready) begin
            ir_reg    <= bus.instr;
            state_reg <= S_DECODE;
          end
        end

        S_DECODE: begin
          if (ir_reg == '0) begin
            halted_reg <= 1'b1;
            state_reg  <= S_HALT;
          end else begin
            state_reg  <= S_EXEC;
          end
        end

        S_EXEC: begin
          // Default: sequential flow (non-branch or branch not taken)
          ps_reg    <= PS_INC;
          pc_in_reg <= '0;
          link_reg  <= 1'b0;
          case (br_class)
            BR_B: begin
              ps_reg    <= PS_BRANCH;
              pc_in_reg <= sext_imm26(ir_reg[25:0]);
            end
            BR_BL: begin
              ps_reg    <= PS_BRANCH;
              pc_in_reg <= sext_imm26(ir_reg[25:0]);
              link_reg  <= 1'b1;
            end
            BR_CBZ: begin
              if (bus.alu_zero) begin
                ps_reg    <= PS_BRANCH;
                pc_in_reg <= sext_imm19(ir_reg[23:5]);
              end
            end
            BR_CBNZ: begin
              if (!bus.alu_zero) begin
                ps_reg    <= PS_BRANCH;
                pc_in_reg <= sext_imm19(ir_reg[23:5]);
              end
            end
            BR_BCOND: begin
              if (cond_take) begin
                ps_reg    <= PS_BRANCH;
                pc_in_reg <= sext_imm19(ir_reg[23:5]);
              end
            end
            BR_REG: begin
              ps_reg    <= PS_LOAD;
              pc_in_reg <= bus.reg_target;
            end
            default: ;
          endcase
          state_reg <= S_UPDATE;
        end

        S_UPDATE: begin
          ps_reg      <= PS_HOLD;
          pc_in_reg   <= '0;
          link_reg    <= 1'b0;
          retired_reg <= retired_reg + RETIRE_W'(1);
          state_reg   <= S_FETCH;
        end

        S_HALT: begin
          halted_reg <= 1'b1;
        end

        default: begin
          state_reg <= S_FETCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Testbench for pc_sequencer: directed plan items, a full B.cond sweep and
// randomized instruction mix, each checked against a behavioural model.
module tb_pc_sequencer;

  logic clock = 1'b0;
  logic reset;

  always #5 clock = ~clock;

  pc_sequencer_if #(.RETIRE_W(32)) bus ();

  pc_sequencer #(.RETIRE_W(32)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_retired;
  logic [31:0] last_ir;

  typedef struct packed {
    logic [1:0]  ps;
    logic [63:0] pc;
    logic        link;
  } upd_t;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    assert (got === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Condition table written straight from the architectural definitions
  function automatic logic cond_model(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cf, v;
    n = f[3]; z = f[2]; cf = f[1]; v = f[0];
    case (c)
      4'd0:    return z;
      4'd1:    return !z;
      4'd2:    return cf;
      4'd3:    return !cf;
      4'd4:    return n;
      4'd5:    return !n;
      4'd6:    return v;
      4'd7:    return !v;
      4'd8:    return cf && !z;
      4'd9:    return !(cf && !z);
      4'd10:   return n == v;
      4'd11:   return n != v;
      4'd12:   return !z && (n == v);
      4'd13:   return !(!z && (n == v));
      default: return 1'b1;
    endcase
  endfunction

  // Expected UPDATE-cycle outputs of one instruction
  function automatic upd_t model_update(input logic [31:0] i, input logic az,
                                        input logic [3:0] fl, input logic [63:0] rt);
    upd_t   r;
    longint off26, off19;
    logic   take;
    off26 = longint'(i[25:0]);
    if (i[25]) off26 = off26 - (longint'(1) << 26);
    off19 = longint'(i[23:5]);
    if (i[23]) off19 = off19 - (longint'(1) << 19);
    r.ps = 2'b10; r.pc = 64'd0; r.link = 1'b0;
    if (i[31:26] == 6'b000101 || i[31:26] == 6'b100101) begin
      r.ps = 2'b11; r.pc = off26; r.link = i[31];
    end else if (i[31:25] == 7'b1011010) begin
      take = i[24] ? !az : az;
      if (take) begin r.ps = 2'b11; r.pc = off19; end
    end else if (i[31:24] == 8'h54) begin
      if (cond_model(i[3:0], fl)) begin r.ps = 2'b11; r.pc = off19; end
    end else if (i[31:21] == 11'b11010110000) begin
      r.ps = 2'b01; r.pc = rt;
    end
    return r;
  endfunction

  // One full non-zero instruction, starting and ending at a negedge in FETCH
  task automatic run_instr(input logic [31:0] i, input logic az, input logic [3:0] fl,
                           input logic [63:0] rt, input int stall, input string tag);
    upd_t e;
    e = model_update(i, az, fl, rt);
    bus.instr = i; bus.alu_zero = az; bus.flags = fl; bus.reg_target = rt;
    bus.imem_ready = 1'b0;
    for (int k = 0; k < stall; k++) begin
      @(negedge clock);
      check({tag, ".stall_ps"}, 64'(bus.PS), 64'd0);
      check({tag, ".stall_ir"}, 64'(bus.ir), 64'(last_ir));
    end
    bus.imem_ready = 1'b1;
    #1;
    check({tag, ".ir_load"}, 64'(bus.ir_load), 64'd1);
    check({tag, ".fetch_ps"}, 64'(bus.PS), 64'd0);
    @(negedge clock);
    bus.imem_ready = 1'b0;
    check({tag, ".ir"}, 64'(bus.ir), 64'(i));
    check({tag, ".decode_ps"}, 64'(bus.PS), 64'd0);
    check({tag, ".decode_ir_load"}, 64'(bus.ir_load), 64'd0);
    @(negedge clock);
    check({tag, ".exec_ps"}, 64'(bus.PS), 64'd0);
    @(negedge clock);
    check({tag, ".upd_ps"}, 64'(bus.PS), 64'(e.ps));
    check({tag, ".upd_pc_in"}, bus.PC_in, e.pc);
    check({tag, ".upd_link"}, 64'(bus.link_write), 64'(e.link));
    $display("txn %0s instr=%h PS=%b PC_in=%h link=%b", tag, i, bus.PS, bus.PC_in, bus.link_write);
    exp_retired = exp_retired + 32'd1;
    @(negedge clock);
    check({tag, ".after_ps"}, 64'(bus.PS), 64'd0);
    check({tag, ".after_pc_in"}, bus.PC_in, 64'd0);
    check({tag, ".after_link"}, 64'(bus.link_write), 64'd0);
    check({tag, ".retired"}, 64'(bus.retired), 64'(exp_retired));
    last_ir = i;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.imem_ready = 1'b1;
    bus.instr = 32'h8B02_0020;
    repeat (2) @(negedge clock);
    check("rst.ps", 64'(bus.PS), 64'd0);
    check("rst.ir", 64'(bus.ir), 64'd0);
    check("rst.retired", 64'(bus.retired), 64'd0);
    check("rst.ir_load", 64'(bus.ir_load), 64'd0);
    check("rst.link", 64'(bus.link_write), 64'd0);
    check("rst.halted", 64'(bus.halted), 64'd0);
    check("rst.pc_in", bus.PC_in, 64'd0);
    reset = 1'b0;
    bus.imem_ready = 1'b0;
    exp_retired = 32'd0;
    last_ir = 32'd0;
  endtask

  initial begin
    logic [31:0] ri;
    logic [3:0]  cc;
    bus.instr = 32'd0; bus.imem_ready = 1'b0; bus.alu_zero = 1'b0;
    bus.flags = 4'd0; bus.reg_target = 64'd0;
    reset = 1'b1;
    exp_retired = 32'd0;
    last_ir = 32'd0;

    // Reset and directed plan items
    do_reset();
    run_instr(32'h8B02_0020, 1'b0, 4'b0000, 64'd0, 0, "add");
    run_instr(32'h17FF_FFFE, 1'b0, 4'b0000, 64'd0, 1, "b_m2");
    run_instr(32'hB400_0060, 1'b1, 4'b0000, 64'd0, 0, "cbz_taken");
    run_instr(32'hB400_0060, 1'b0, 4'b0000, 64'd0, 0, "cbz_not");
    run_instr(32'h5400_004C, 1'b0, 4'b0000, 64'd0, 0, "bgt_taken");
    run_instr(32'h5400_004C, 1'b0, 4'b1000, 64'd0, 0, "bgt_not");
    run_instr(32'h9400_0005, 1'b0, 4'b0000, 64'd0, 0, "bl_p5");
    run_instr(32'hD61F_0020, 1'b0, 4'b0000, 64'h400, 0, "br_400");
    run_instr(32'hB5FF_FFE0, 1'b0, 4'b0000, 64'd0, 7, "cbnz_stall7");

    // Full condition x flag sweep through the sequencer
    for (int c = 0; c < 16; c++) begin
      for (int f = 0; f < 16; f++) begin
        ri = {8'h54, 19'($urandom), 1'b0, 4'(c)};
        run_instr(ri, 1'($urandom_range(0, 1)), 4'(f), 64'd0, 0,
                  $sformatf("bcond_c%0d_f%0d", c, f));
      end
    end

    // Randomized instruction mix
    for (int n = 0; n < 150; n++) begin
      case ($urandom_range(0, 6))
        0: begin ri = $urandom; if (ri == 32'd0) ri = 32'd1; end
        1: ri = {6'b000101, 26'($urandom)};
        2: ri = {6'b100101, 26'($urandom)};
        3: ri = {8'hB4, 24'($urandom)};
        4: ri = {8'hB5, 24'($urandom)};
        5: begin cc = 4'($urandom); ri = {8'h54, 19'($urandom), 1'b0, cc}; end
        default: ri = {11'b11010110000, 5'b11111, 6'd0, 5'($urandom), 5'd0};
      endcase
      run_instr(ri, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                {$urandom, $urandom}, $urandom_range(0, 3), $sformatf("rand%0d", n));
    end

    // Reset asserted during EXEC abandons the instruction without a PS pulse
    bus.instr = 32'h9400_0005; bus.imem_ready = 1'b1;
    @(negedge clock);
    bus.imem_ready = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("rexec.ps", 64'(bus.PS), 64'd0);
    check("rexec.ir", 64'(bus.ir), 64'd0);
    check("rexec.retired", 64'(bus.retired), 64'd0);
    check("rexec.link", 64'(bus.link_write), 64'd0);
    reset = 1'b0;
    exp_retired = 32'd0;
    last_ir = 32'd0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      check("rexec.no_pulse", 64'(bus.PS), 64'd0);
    end
    $display("txn reset_in_exec retired=%0d", bus.retired);
    run_instr(32'h8B02_0020, 1'b0, 4'b0000, 64'd0, 0, "add_after_rst");

    // All-zero instruction halts; imem_ready then ignored until reset
    bus.instr = 32'h0000_0000; bus.imem_ready = 1'b1;
    @(negedge clock);
    bus.instr = 32'h8B02_0020;
    @(negedge clock);
    check("halt.halted", 64'(bus.halted), 64'd1);
    for (int k = 0; k < 6; k++) begin
      @(negedge clock);
      check("halt.stay", 64'(bus.halted), 64'd1);
      check("halt.ps", 64'(bus.PS), 64'd0);
      check("halt.ir", 64'(bus.ir), 64'd0);
      check("halt.retired", 64'(bus.retired), 64'(exp_retired));
    end
    $display("txn halt halted=%b", bus.halted);
    do_reset();
    run_instr(32'h17FF_FFFE, 1'b0, 4'b0000, 64'd0, 0, "b_after_halt");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Multicycle control unit that drives the program counter's 2-bit next-PC select (PS) and branch operand bus for the 64-bit LEGv8 core. Fetches each instruction into an internal instruction register, decodes branch class, resolves branch conditions from ALU/status flags, and issues exactly one PC update per instruction. Sits between instruction memory, the ALU flag outputs and the program counter.

Parameters:
RETIRE_W, 32, width of retired-instruction counter

Ports:
clock  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
instr  input  32  instruction memory read data
imem_ready  input  1  instr valid this cycle
alu_zero  input  1  ALU zero result, valid in EXEC
flags  input  4  registered status flags {N,Z,C,V}
reg_target  input  64  register-file read value (BR target)
PS  output  2  PC select: 00 hold, 01 load PC_in, 10 PC+4, 11 PC+4+(PC_in<<2)
PC_in  output  64  PC operand: absolute target (PS=01) or signed word offset (PS=11)
ir  output  32  instruction register
ir_load  output  1  IR capture strobe
link_write  output  1  BL: write PC4 to X30 this cycle
halted  output  1  sequencer in HALT
retired  output  RETIRE_W  instructions completed, wraps

Behaviour:
- States: FETCH, DECODE, EXEC, UPDATE, HALT. Registered state, outputs decoded from state + IR.
- Reset (sync, any state): state=FETCH, ir=0, retired=0, PS=00, ir_load=0, link_write=0, halted=0. Abandons any in-flight instruction; no PS pulse issued.
- FETCH: PS=00. If imem_ready: ir_load=1, ir<=instr, ->DECODE. Else stay (unbounded wait).
- DECODE: PS=00. If ir==32'h0000_0000 ->HALT, else ->EXEC.
- EXEC: PS=00. Resolve `take` (registered on exit):
  B (ir[31:26]=000101), BL (100101): take=1.
  CBZ (ir[31:24]=10110100): take=alu_zero; CBNZ (10110101): take=!alu_zero.
  B.cond (ir[31:24]=01010100): take=cond(ir[3:0], flags): EQ Z; NE !Z; HS C; LO !C; MI N; PL !N; VS V; VC !V; HI C&!Z; LS !(C&!Z); GE N==V; LT N!=V; GT !Z&(N==V); LE !(!Z&(N==V)); 1110/1111 always.
  BR (ir[31:21]=11010110000): take=1.
  Any other: non-branch, take=0. ->UPDATE.
- UPDATE (exactly one cycle): PS and PC_in:
  non-branch or not taken: PS=10.
  B/BL taken: PS=11, PC_in=sign-extend(ir[25:0]) to 64.
  CB/B.cond taken: PS=11, PC_in=sign-extend(ir[23:5]) to 64.
  BR: PS=01, PC_in=reg_target.
  BL: link_write=1 same cycle.
  retired<=retired+1 (mod 2^RETIRE_W); ->FETCH.
- PC_in=0 whenever PS is 00 or 10.
- HALT: PS=00, halted=1, ignores imem_ready; leaves only via reset.
- Non-zero PS: exactly one cycle per instruction, minimum 4 cycles/instruction. PC offset is PC+4-relative (PC applies +4 in mode 11); branch offsets are encoded accordingly.
- imem_ready outside FETCH: ignored.

Decomposition:
- Shared package legv8_pkg: state enum, PS encodings (PS_HOLD, PS_LOAD, PS_INC, PS_BRANCH), opcode constants (OP_B, OP_BL, OP_CBZ, OP_CBNZ, OP_BCOND, OP_BR), cond-code constants.
- One sub-module: cond_eval (combinational cond[3:0] x flags -> take), reusable by the pipelined core.

Test Plan:
- Reset then instr=ADD (32'h8B02_0020), imem_ready=1 -> PS sequence 00,00,00,10 with ir_load in cycle 1; retired=1.
- B offset -2 (32'h17FF_FFFE) -> UPDATE cycle PS=11, PC_in=64'hFFFF_FFFF_FFFF_FFFE.
- CBZ offset +3 (32'hB400_0060): alu_zero=1 -> PS=11, PC_in=3; repeat with alu_zero=0 -> PS=10, PC_in=0.
- B.GT (cond 1100) flags {N,Z,C,V}=0000 -> taken PS=11; flags=1000 -> PS=10; sweep all 16 cond x 16 flags against cond_eval model.
- BL offset +5 -> PS=11, PC_in=5, link_write=1 same single cycle; BR with reg_target=64'h400 -> PS=01, PC_in=64'h400.
- imem_ready low 7 cycles -> PS held 00, ir unchanged; instr=0 -> halted=1 and stays; reset asserted in EXEC -> next cycle FETCH, no PS pulse, retired=0.
